// File: rtl/cp0_irq_ctrl_pkg.sv
// Shared CP0 constants: register addresses, operation codes and STATUS/CAUSE field offsets.
// Imported by the interrupt controller and its priority encoder.
package cp0_irq_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_MFC0 = 2'b01,
        OP_MTC0 = 2'b10,
        OP_ERET = 2'b11
    } cp0_oper_e;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;
    localparam logic [4:0] CP0_EHBR   = 5'd15;

    localparam int STATUS_IE_BIT = 0;
    localparam int STATUS_IM_LSB = 8;
    localparam int CAUSE_IDX_W   = 5;
    localparam int CAUSE_IP_LSB  = 8;

endpackage

// File: rtl/cp0_prio_enc.sv
// Fixed-priority encoder: bit 0 has the highest priority; returns valid plus 5-bit index.
// Shared with the exception unit.
module cp0_prio_enc
    import cp0_irq_ctrl_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]             req_i,
    output logic                     valid_o,
    output logic [CAUSE_IDX_W-1:0]   idx_o
);

    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        // Scan downwards so the lowest set bit is the last assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = CAUSE_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/cp0_irq_ctrl.sv
// CP0 interrupt controller: STATUS/CAUSE/EPC/EHBR, fixed-priority entry and ERET force-jump.
// Optional build macro CP0_VECTORED_IRQ_EN spaces entry vectors by 2**VEC_SH bytes from EHBR.
module cp0_irq_ctrl
    import cp0_irq_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int DATA_W  = 32,
    parameter int VEC_SH  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         oper,
    input  logic [4:0]         addr_r,
    output logic [DATA_W-1:0]  data_r,
    input  logic [4:0]         addr_w,
    input  logic [DATA_W-1:0]  data_w,
    input  logic               ir_en,
    input  logic [NUM_IRQ-1:0] ir_in,
    input  logic [DATA_W-1:0]  ret_addr,
    output logic               jump_en,
    output logic [DATA_W-1:0]  jump_addr
);

    if (NUM_IRQ < 1 || NUM_IRQ > 16) begin : g_bad_num_irq
        $error("cp0_irq_ctrl: NUM_IRQ must be in 1..16");
    end
    if (VEC_SH < 0 || VEC_SH >= DATA_W) begin : g_bad_vec_sh
        $error("cp0_irq_ctrl: VEC_SH must be below DATA_W");
    end

    logic                   ie_q, ie_d;
    logic [NUM_IRQ-1:0]     im_q, im_d;
    logic [NUM_IRQ-1:0]     pend_q, pend_d;
    logic [CAUSE_IDX_W-1:0] cause_idx_q, cause_idx_d;
    logic [DATA_W-1:0]      epc_q, epc_d;
    logic [DATA_W-1:0]      ehbr_q, ehbr_d;
    logic                   in_service_q, in_service_d;

    logic [NUM_IRQ-1:0]     req;
    logic                   req_valid;
    logic [CAUSE_IDX_W-1:0] win_idx;
    logic                   is_eret, is_mtc0, take;
    logic [NUM_IRQ-1:0]     pend_clr;
    logic [DATA_W-1:0]      entry_addr;

    assign req     = pend_q & im_q;
    assign is_eret = (oper == OP_ERET);
    assign is_mtc0 = (oper == OP_MTC0);
    assign take    = ir_en & ie_q & ~in_service_q & req_valid & ~is_eret;

    cp0_prio_enc #(
        .N (NUM_IRQ)
    ) u_prio_enc (
        .req_i   (req),
        .valid_o (req_valid),
        .idx_o   (win_idx)
    );

`ifdef CP0_VECTORED_IRQ_EN
    assign entry_addr = ehbr_q + (DATA_W'(win_idx) << VEC_SH);
`else
    assign entry_addr = ehbr_q;
`endif

    always_comb begin
        jump_en   = 1'b0;
        jump_addr = entry_addr;
        if (!rst) begin
            jump_en = is_eret | take;
        end
        if (is_eret) begin
            jump_addr = epc_q;
        end
    end

    always_comb begin
        data_r = '0;
        case (addr_r)
            CP0_STATUS: begin
                data_r[STATUS_IE_BIT]              = ie_q;
                data_r[STATUS_IM_LSB +: NUM_IRQ]   = im_q;
            end
            CP0_CAUSE: begin
                data_r[CAUSE_IDX_W-1:0]            = cause_idx_q;
                data_r[CAUSE_IP_LSB +: NUM_IRQ]    = pend_q;
            end
            CP0_EPC:  data_r = epc_q;
            CP0_EHBR: data_r = ehbr_q;
            default:  data_r = '0;
        endcase
    end

    always_comb begin
        ie_d         = ie_q;
        im_d         = im_q;
        cause_idx_d  = cause_idx_q;
        epc_d        = epc_q;
        ehbr_d       = ehbr_q;
        in_service_d = in_service_q;
        pend_clr     = '0;

        for (int i = 0; i < NUM_IRQ; i++) begin
            if (is_eret && cause_idx_q == CAUSE_IDX_W'(i)) begin
                pend_clr[i] = 1'b1;
            end
        end
        // A software CAUSE write racing an entry is dropped in favour of the hardware update.
        if (is_mtc0 && addr_w == CP0_CAUSE && !take) begin
            pend_clr = pend_clr | data_w[CAUSE_IP_LSB +: NUM_IRQ];
        end
        pend_d = (pend_q & ~pend_clr) | ir_in;

        if (is_mtc0) begin
            case (addr_w)
                CP0_STATUS: begin
                    ie_d = data_w[STATUS_IE_BIT];
                    im_d = data_w[STATUS_IM_LSB +: NUM_IRQ];
                end
                CP0_EPC:  epc_d  = data_w;
                CP0_EHBR: ehbr_d = data_w;
                default: ;
            endcase
        end

        if (take) begin
            epc_d        = ret_addr;
            cause_idx_d  = win_idx;
            in_service_d = 1'b1;
        end
        if (is_eret) begin
            in_service_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ie_q         <= 1'b1;
            im_q         <= '1;
            pend_q       <= '0;
            cause_idx_q  <= '0;
            epc_q        <= '0;
            ehbr_q       <= '0;
            in_service_q <= 1'b0;
        end else begin
            ie_q         <= ie_d;
            im_q         <= im_d;
            pend_q       <= pend_d;
            cause_idx_q  <= cause_idx_d;
            epc_q        <= epc_d;
            ehbr_q       <= ehbr_d;
            in_service_q <= in_service_d;
        end
    end

endmodule
